// File: rtl/render_scheduler.sv
// render_scheduler: walks the object table once per frame, fetching four records per batch for the 4-lane renderer.
// Optional macro STATIC_SKIP_EN adds static_cached_in, which drops is_static records from batches.

module render_sched_lane #(
  parameter int ADDR_W = 7,
  parameter int OBJ_W  = 115
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clr,
  input  logic              cap,
  input  logic              skip_static,
  input  logic [ADDR_W-1:0] addr,
  input  logic [OBJ_W-1:0]  data,
  output logic              vld_nxt,
  output logic              vld,
  output logic [ADDR_W-1:0] addr_q,
  output logic [OBJ_W-1:0]  data_q
);
  logic rec_vld;
  assign rec_vld = (data[1:0] != 2'b00) && !(skip_static && data[2]);

  // look-ahead valid lets the FSM decide dispatch/skip on the landing cycle
  always_comb begin
    vld_nxt = vld;
    if (clr)      vld_nxt = 1'b0;
    else if (cap) vld_nxt = rec_vld;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld    <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (clr) begin
      vld    <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (cap) begin
      vld    <= rec_vld;
      addr_q <= addr;
      data_q <= data;
    end
  end
endmodule

module render_scheduler #(
  parameter int NUM_OBJ = 128,
  parameter int ADDR_W  = 7,
  parameter int OBJ_W   = 115,
  parameter int RD_LAT  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
`ifdef STATIC_SKIP_EN
  input  logic                  static_cached_in,
`endif
  input  logic [ADDR_W:0]       obj_count_in,
  output logic                  mem_rd_out,
  output logic [ADDR_W-1:0]     mem_addr_out,
  input  logic [OBJ_W-1:0]      mem_data_in,
  output logic                  batch_valid_out,
  output logic [3:0]            batch_lane_valid_out,
  output logic [4*ADDR_W-1:0]   batch_addr_out,
  output logic [4*OBJ_W-1:0]    batch_data_out,
  input  logic                  render_busy_in,
  input  logic                  render_done_in,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [ADDR_W-2:0]     batch_count_out
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, FETCH, COLLECT, DISPATCH, WAIT_RENDER, NEXT, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W:0]   count_q, base_q, count_clamp, slot, base_inc;
  logic [1:0]        idx_q;
  logic [ADDR_W-2:0] batch_cnt_q;
  logic              frame_done_q;
  logic              rd_now, inflight, skip_static;

  logic [RD_LAT:1]                        vld_pipe;
  logic [RD_LAT:1][1:0]                   lane_pipe;
  logic [NUM_LANES-1:0]                   lane_cap, lane_vld, lane_vld_nxt;
  logic [NUM_LANES-1:0][ADDR_W-1:0]       lane_addr;
  logic [NUM_LANES-1:0][OBJ_W-1:0]        lane_data;

  assign count_clamp = (obj_count_in > (ADDR_W+1)'(NUM_OBJ)) ? (ADDR_W+1)'(NUM_OBJ) : obj_count_in;
  assign slot        = base_q + (ADDR_W+1)'(idx_q);
  assign base_inc    = base_q + (ADDR_W+1)'(NUM_LANES);
  assign rd_now      = (state == FETCH) && (slot < count_q);

`ifdef STATIC_SKIP_EN
  logic static_q;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                 static_q <= 1'b0;
    else if (state == IDLE && frame_start_in)   static_q <= static_cached_in;
  end
  assign skip_static = static_q;
`else
  assign skip_static = 1'b0;
`endif

  // read-tag shift register: stage k holds the lane of the read issued k cycles ago
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_pipe  <= '0;
      lane_pipe <= '0;
    end else begin
      vld_pipe[1]  <= rd_now;
      lane_pipe[1] <= idx_q;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        lane_pipe[k] <= lane_pipe[k-1];
      end
    end
  end

  if (RD_LAT > 1) begin : g_inflight
    assign inflight = |vld_pipe[RD_LAT-1:1];
  end else begin : g_no_inflight
    assign inflight = 1'b0;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_cap[i] = vld_pipe[RD_LAT] && (lane_pipe[RD_LAT] == 2'(i));
    render_sched_lane #(.ADDR_W(ADDR_W), .OBJ_W(OBJ_W)) u_lane (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .clr         (state == FETCH && idx_q == 2'd0),
      .cap         (lane_cap[i]),
      .skip_static (skip_static),
      .addr        (base_q[ADDR_W-1:0] + ADDR_W'(i)),
      .data        (mem_data_in),
      .vld_nxt     (lane_vld_nxt[i]),
      .vld         (lane_vld[i]),
      .addr_q      (lane_addr[i]),
      .data_q      (lane_data[i])
    );
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    mem_rd_out      = rd_now;
    mem_addr_out    = rd_now ? slot[ADDR_W-1:0] : '0;
    batch_valid_out = (state == DISPATCH);
    busy_out        = (state != IDLE);
    case (state)
      IDLE:        if (frame_start_in) state_nxt = (count_clamp == '0) ? DONE : FETCH;
      FETCH:       if (idx_q == 2'd3) state_nxt = COLLECT;
      COLLECT:     if (!inflight) state_nxt = (|lane_vld_nxt) ? DISPATCH : NEXT;
      DISPATCH:    if (!render_busy_in) state_nxt = WAIT_RENDER;
      WAIT_RENDER: if (render_done_in) state_nxt = NEXT;
      NEXT:        state_nxt = (base_inc >= count_q) ? DONE : FETCH;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q      <= '0;
      base_q       <= '0;
      idx_q        <= '0;
      batch_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state == DONE);
      case (state)
        IDLE: if (frame_start_in) begin
          count_q     <= count_clamp;
          base_q      <= '0;
          idx_q       <= '0;
          batch_cnt_q <= '0;
        end
        FETCH:    idx_q <= idx_q + 2'd1;
        DISPATCH: if (!render_busy_in) batch_cnt_q <= batch_cnt_q + 1'b1;
        NEXT:     base_q <= base_inc;
        default:  ;
      endcase
    end
  end

  assign batch_lane_valid_out = lane_vld;
  assign batch_addr_out       = lane_addr;
  assign batch_data_out       = lane_data;
  assign frame_done_out       = frame_done_q;
  assign batch_count_out      = batch_cnt_q;
endmodule

// File: tb/tb_render_scheduler.sv
// Randomized bench for render_scheduler: object-table model, batch scoreboard built from slot rules.
module tb_render_scheduler;
  localparam int NUM_OBJ = 128, ADDR_W = 7, OBJ_W = 115, RD_LAT = 2;
  localparam logic [OBJ_W-1:0] JUNK = {{(OBJ_W-2){1'b1}}, 2'b01};

  logic clk_in, rst_in, frame_start_in, mem_rd_out, batch_valid_out;
  logic render_busy_in, render_done_in, busy_out, frame_done_out;
  logic [ADDR_W:0]     obj_count_in;
  logic [ADDR_W-1:0]   mem_addr_out;
  logic [OBJ_W-1:0]    mem_data_in;
  logic [3:0]          batch_lane_valid_out;
  logic [4*ADDR_W-1:0] batch_addr_out;
  logic [4*OBJ_W-1:0]  batch_data_out;
  logic [ADDR_W-2:0]   batch_count_out;
`ifdef STATIC_SKIP_EN
  logic static_cached_in;
`endif

  render_scheduler #(.NUM_OBJ(NUM_OBJ), .ADDR_W(ADDR_W), .OBJ_W(OBJ_W), .RD_LAT(RD_LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
`ifdef STATIC_SKIP_EN
    .static_cached_in(static_cached_in),
`endif
    .obj_count_in(obj_count_in), .mem_rd_out(mem_rd_out), .mem_addr_out(mem_addr_out),
    .mem_data_in(mem_data_in), .batch_valid_out(batch_valid_out),
    .batch_lane_valid_out(batch_lane_valid_out), .batch_addr_out(batch_addr_out),
    .batch_data_out(batch_data_out), .render_busy_in(render_busy_in),
    .render_done_in(render_done_in), .busy_out(busy_out), .frame_done_out(frame_done_out),
    .batch_count_out(batch_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // object-table memory with RD_LAT-cycle read latency
  logic [OBJ_W-1:0]  obj_mem [NUM_OBJ];
  logic [ADDR_W-1:0] pa [RD_LAT+1];
  logic              pv [RD_LAT+1];
  always @(posedge clk_in) begin
    pv[1] <= mem_rd_out;
    pa[1] <= mem_addr_out;
    for (int k = 2; k <= RD_LAT; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
  end
  assign mem_data_in = pv[RD_LAT] ? obj_mem[pa[RD_LAT]] : JUNK;

  typedef struct { int base; logic [3:0] lv; } exp_b_t;

  int n_chk = 0, n_bad = 0;
  int t_first_rd, t_first_bv, t_done, disp1_cycles, last_rd;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem();
    for (int a = 0; a < NUM_OBJ; a++)
      obj_mem[a] = OBJ_W'({$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic run_frame(input int oc, input bit st, input int busy_pct, input int hold,
                           input int done_max, input bit spur);
    int cnt, nb, cyc, done_cnt, hc, a, nd;
    exp_b_t eb[$];
    exp_b_t cur;
    int er[$], gr[$];
    logic [3:0] lv;
    logic [4*OBJ_W-1:0]  sd;
    logic [4*ADDR_W-1:0] sa;
    logic [3:0] sl;
    bit in_disp;
    cnt = (oc > NUM_OBJ) ? NUM_OBJ : oc;
    for (int b = 0; b < cnt; b += 4) begin
      lv = '0;
      for (int i = 0; i < 4; i++)
        if (b + i < cnt) begin
          er.push_back(b + i);
          if (obj_mem[b+i][1:0] != 2'b00 && !(st && obj_mem[b+i][2])) lv[i] = 1'b1;
        end
      if (lv != 4'b0) eb.push_back('{b, lv});
    end
    nb = eb.size();
    t_first_rd = -1; t_first_bv = -1; t_done = -1; disp1_cycles = 0; last_rd = -1;
    in_disp = 0; done_cnt = -1; hc = hold; nd = 0; cur = '{-1, 4'b0};

    @(posedge clk_in); #1;
    frame_start_in = 1'b1;
    obj_count_in   = 8'(oc);
`ifdef STATIC_SKIP_EN
    static_cached_in = st;
`endif
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk_in); #1;
      cyc++;
      frame_start_in = 1'b0;
      render_done_in = 1'b0;
      if (mem_rd_out) begin
        gr.push_back(int'(mem_addr_out));
        if (t_first_rd < 0) t_first_rd = cyc;
      end
      if (frame_done_out) begin
        t_done = cyc;
        chk("done_busy", busy_out, 0);
        chk("batch_cnt", batch_count_out, nb);
        break;
      end
      if (batch_valid_out) begin
        if (!in_disp) begin
          in_disp = 1;
          if (t_first_bv < 0) t_first_bv = cyc;
          if (eb.size() == 0) chk("extra_batch", 1, 0);
          else begin
            cur = eb.pop_front();
            chk("lane_vld", batch_lane_valid_out, cur.lv);
            for (int i = 0; i < 4; i++) begin
              a = cur.base + i;
              if (a >= cnt) chk("pad_data", batch_data_out[i*OBJ_W +: OBJ_W], 0);
              else if (cur.lv[i]) begin
                chk("lane_addr", batch_addr_out[i*ADDR_W +: ADDR_W], a);
                chk("lane_data", batch_data_out[i*OBJ_W +: OBJ_W], obj_mem[a]);
              end
            end
          end
          sd = batch_data_out; sa = batch_addr_out; sl = batch_lane_valid_out;
        end else
          chk("hold_stable", (sd == batch_data_out) && (sa == batch_addr_out) && (sl == batch_lane_valid_out), 1);
        if (nd == 0) disp1_cycles++;
        if (hc > 0) begin render_busy_in = 1'b1; hc--; end
        else render_busy_in = ($urandom_range(99) < busy_pct);
        if (!render_busy_in) begin
          in_disp = 0; nd++;
          done_cnt = $urandom_range(done_max);
        end
      end else begin
        render_busy_in = $urandom_range(1);
        if (done_cnt == 0) begin render_done_in = 1'b1; done_cnt = -1; end
        else if (done_cnt > 0) done_cnt--;
        if (spur && mem_rd_out && $urandom_range(2) == 0) begin
          frame_start_in = 1'b1;
          obj_count_in   = 8'($urandom());
          render_done_in = 1'b1;
        end
      end
    end
    render_busy_in = 1'b0; render_done_in = 1'b0; frame_start_in = 1'b0;
    if (t_done < 0) chk("frame_timeout", 1, 0);
    chk("rd_count", gr.size(), er.size());
    for (int i = 0; i < gr.size() && i < er.size(); i++) chk("rd_addr", gr[i], er[i]);
    chk("batches_left", eb.size(), 0);
    if (gr.size() > 0) last_rd = gr[gr.size()-1];
    @(posedge clk_in); #1;
    chk("done_pulse", frame_done_out, 0);
  endtask

  initial begin
    rst_in = 1'b1; frame_start_in = 1'b0; obj_count_in = '0;
    render_busy_in = 1'b0; render_done_in = 1'b0;
`ifdef STATIC_SKIP_EN
    static_cached_in = 1'b0;
`endif
    fill_mem();
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_rd", mem_rd_out, 0);
    chk("rst_bv", batch_valid_out, 0);
    chk("rst_lv", batch_lane_valid_out, 0);
    chk("rst_data", batch_data_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_cnt", batch_count_out, 0);
    rst_in = 1'b0;

    // full batch of circles, no backpressure
    for (int a = 0; a < 4; a++) obj_mem[a][1:0] = 2'b01;
    run_frame(4, 0, 0, 0, 0, 0);
    chk("first_rd_t", t_first_rd, 1);
    chk("bv_lat", t_first_bv - t_first_rd, 4 + RD_LAT);

    // partial last batch with an empty slot
    fill_mem();
    for (int a = 0; a < 8; a++) obj_mem[a][1:0] = 2'b01;
    obj_mem[1][1:0] = 2'b00;
    run_frame(6, 0, 0, 0, 2, 0);

    // backpressure held for 10 cycles
    run_frame(4, 0, 0, 10, 1, 0);
    chk("bp_cycles", disp1_cycles, 11);

    // empty frame and clamp
    run_frame(0, 0, 0, 0, 0, 0);
    chk("empty_done_t", t_done, 2);
    chk("empty_no_rd", t_first_rd, -1);
    fill_mem();
    run_frame(200, 0, 20, 0, 2, 0);
    chk("clamp_last", last_rd, 127);

    // reset mid-COLLECT, then restart
    for (int a = 0; a < 8; a++) obj_mem[a][1:0] = 2'b11;
    @(posedge clk_in); #1;
    frame_start_in = 1'b1; obj_count_in = 8'd8;
    @(posedge clk_in); #1;
    frame_start_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk("pre_rst_busy", busy_out, 1);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_data", batch_data_out, 0);
    chk("mid_rst_lv", batch_lane_valid_out, 0);
    chk("mid_rst_rd", mem_rd_out, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_in); #1;
      chk("abort_no_done", frame_done_out, 0);
    end
    run_frame(8, 0, 0, 0, 1, 0);

`ifdef STATIC_SKIP_EN
    for (int a = 0; a < 4; a++) obj_mem[a][2:0] = 3'b101;
    run_frame(4, 1, 0, 0, 0, 0);
    chk("static_no_bv", t_first_bv, -1);
    chk("static_done", t_done > 0, 1);
`endif

    // randomized frames with spurious start/done during FETCH
    for (int f = 0; f < 8; f++) begin
      fill_mem();
`ifdef STATIC_SKIP_EN
      run_frame($urandom_range(200), $urandom_range(1), 30, 0, 3, 1);
`else
      run_frame($urandom_range(200), 0, 30, 0, 3, 1);
`endif
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
- Sequences the shape-render datapath once per frame: walks the object table, fetches object records four at a time, and presents each batch to the four-lane renderer.
- Uses a valid/busy handshake for the batch, then waits for the renderer's completion pulse before fetching the next batch.
- Sits between the object-table memory (physics side) and the render block; it is the only master of the object-table read port during rendering.

Parameters:
- NUM_OBJ, 128: object-table depth, in slots.
- ADDR_W, 7: object-table address width; must satisfy 2**ADDR_W >= NUM_OBJ.
- OBJ_W, 115: object record width.
  - Bits [1:0]: id (00 empty, 01 circle, 10 line, 11 rectangle).
  - Bit [2]: is_static.
  - Remaining bits: opaque.
- RD_LAT, 2: object-table read latency in cycles (1..4).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- frame_start_in  input  1  one-cycle pulse that starts a frame pass.
- obj_count_in  input  ADDR_W+1  number of slots to scan; sampled on an accepted frame_start_in.
- mem_rd_out  output  1  object-table read strobe.
- mem_addr_out  output  ADDR_W  object-table read address.
- mem_data_in  input  OBJ_W  read data, valid RD_LAT cycles after mem_rd_out.
- batch_valid_out  output  1  batch presented to the renderer.
- batch_lane_valid_out  output  4  per-lane valid.
- batch_addr_out  output  4*ADDR_W  slot address per lane (lane i at bits [i*ADDR_W +: ADDR_W]).
- batch_data_out  output  4*OBJ_W  record per lane.
- render_busy_in  input  1  renderer cannot accept a batch.
- render_done_in  input  1  one-cycle pulse: current batch fully rendered.
- busy_out  output  1  high in every state except IDLE.
- frame_done_out  output  1  one-cycle pulse at the end of a pass.
- batch_count_out  output  ADDR_W-1  batches dispatched this frame.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including the batch registers and batch_count_out.
  - Reset mid-frame abandons the pass silently; no frame_done_out is produced.
- IDLE:
  - frame_start_in latches count = min(obj_count_in, NUM_OBJ), clears base address and batch_count_out, then goes to FETCH.
  - If count == 0, go directly to DONE instead.
  - frame_start_in in any other state is ignored.
- FETCH:
  - Issues up to 4 reads on consecutive cycles at base+0..base+3.
  - Slots with address >= count are not read; their lane is left invalid.
  - Then goes to COLLECT.
- COLLECT:
  - A delayed copy of the lane tag captures mem_data_in into lane i exactly RD_LAT cycles after read i.
  - lane_valid[i] = 1 only if the slot was read and id != 00.
  - Once the last issued read's data has landed, go to DISPATCH.
  - If no lane is valid, go to NEXT instead, with no dispatch.
- DISPATCH:
  - batch_valid_out = 1; batch outputs are held stable.
  - Transfer occurs on the cycle where batch_valid_out && !render_busy_in.
  - On transfer: batch_valid_out drops the next cycle, batch_count_out increments, go to WAIT_RENDER.
- WAIT_RENDER:
  - render_done_in goes to NEXT.
  - render_done_in in any other state is ignored.
- NEXT:
  - base += 4.
  - If base >= count, go to DONE; else go to FETCH.
- DONE:
  - frame_done_out = 1 for exactly one cycle, then go to IDLE.
  - busy_out falls in the same cycle state becomes IDLE.
- Timing, full batch with render_busy_in low:
  - First mem_rd_out occurs 1 cycle after frame_start_in.
  - batch_valid_out rises 4+RD_LAT cycles after the first read.
- Width rule: base is ADDR_W+1 bits, so base never wraps at NUM_OBJ.
- Partial last batch: lanes above count stay invalid and their data is zeroed.

Optional Feature:
- Macro: STATIC_SKIP_EN.
- When defined:
  - Adds input port static_cached_in (1 bit), sampled with frame_start_in.
  - If the sampled value is 1, lanes whose record has is_static = 1 are marked invalid, because static objects are already in the background buffer.
  - An all-static batch is skipped like an all-empty one.
- When not defined: the port is absent and is_static has no effect on lane valid.

Test Plan:
- Full batch, 4 circle slots: count=4, RD_LAT=2, render_busy_in low.
  -> reads at addresses 0..3 on consecutive cycles; batch_valid_out 6 cycles after the first read; lane_valid=1111.
  -> render_done_in pulse -> frame_done_out one cycle later in DONE; batch_count_out=1.
- Partial and empty slots: count=6, slot 1 id=00.
  -> batch0 lane_valid=1101; batch1 has reads only at addresses 4 and 5, lane_valid=0011.
  -> batch_count_out=2.
- Backpressure: render_busy_in held high for 10 cycles in DISPATCH.
  -> batch_valid_out and all batch data held stable for 10 cycles; transfer on the 11th cycle; no extra reads issued.
- Empty frame and clamping:
  -> count=0: frame_done_out 2 cycles after frame_start_in, mem_rd_out never asserted.
  -> obj_count_in=200 with NUM_OBJ=128: last read address is 127.
- Robustness: frame_start_in and spurious render_done_in during FETCH are ignored; rst_in asserted mid-COLLECT -> all outputs 0 immediately, and the next frame_start_in restarts from address 0.
- STATIC_SKIP_EN with static_cached_in=1: batch of 4 static records -> no batch_valid_out, batch_count_out=0, frame_done_out still pulses.
